// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream; flush rides along.
// Ports: flush, in_valid/in_ready/in_instr/in_pc, out_valid/out_ready plus decoded payload out_*.
// Modports: master = surrounding pipeline (fetch + execute side), slave = decode_stage itself.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [5:0]      out_shamt;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_shamt, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_shamt, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode: field extraction, immediate generation, legality check, 2-entry elastic buffer.
// Latency: 1 cycle from accept to out_*; 1 instr/cycle while out_ready=1.
// Backpressure: in_ready is registered, drops the cycle after the buffer holds two entries.
// Ports: clk, rst (async active-high), bus (decode_stage_if.slave: flush, in_* request, out_* decoded entry).
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      shamt;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  localparam entry_t ENTRY_RST = '{pc: '0, opcode: '0, rd: '0, rs1: '0, rs2: '0,
                                   funct3: '0, funct7: '0, shamt: '0, imm: '0,
                                   fmt: FMT_NONE, illegal: 1'b0};

  logic [31:0] instr;
  logic [2:0]  f3;
  logic [2:0]  fmt;
  logic [31:0] imm32;
  entry_t      dec;

  assign instr = bus.in_instr;
  assign f3    = instr[14:12];

  // Every listed opcode ends in 2'b11, so a non-11 low pair falls to the default arm.
  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111:             fmt = FMT_J;
      7'b1100111:             fmt = (f3 == 3'b000) ? FMT_I : FMT_NONE;
      7'b0000011, 7'b0001111, 7'b1110011: fmt = FMT_I;
      // RV32 shift amounts are 5 bits; instr[25] set would address a 6th bit.
      7'b0010011: fmt = (!RV64 && (f3 == 3'b001 || f3 == 3'b101) && instr[25]) ? FMT_NONE : FMT_I;
      7'b1100011: fmt = (f3 == 3'b010 || f3 == 3'b011) ? FMT_NONE : FMT_B;
      7'b0100011: fmt = FMT_S;
      7'b0110011: fmt = FMT_R;
      7'b0011011: fmt = RV64 ? FMT_I : FMT_NONE;
      7'b0111011: fmt = RV64 ? FMT_R : FMT_NONE;
      default:    fmt = FMT_NONE;
    endcase
  end

  // Immediates are built at 32 bits, then sign-extended to XLEN.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec.pc      = bus.in_pc;
    dec.opcode  = instr[6:0];
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.funct3  = f3;
    dec.funct7  = instr[31:25];
    dec.shamt   = {RV64 ? instr[25] : 1'b0, instr[24:20]};
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = fmt;
    dec.illegal = (fmt == FMT_NONE);
  end

  state_t state_q, state_d;
  entry_t ent0_q, ent0_d;  // oldest entry, drives out_*
  entry_t ent1_q, ent1_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   push, pop;

  always_comb begin
    push    = bus.in_valid & in_ready_q & ~bus.flush;
    pop     = out_valid_q & bus.out_ready;
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (bus.flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (push) begin
          ent0_d  = dec;
          state_d = S_ONE;
        end
        S_ONE: begin
          if (push && pop) begin
            ent0_d = dec;
          end else if (push) begin
            ent1_d  = dec;
            state_d = S_TWO;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: if (pop) begin
          ent0_d  = ent1_q;
          state_d = S_ONE;
        end
        default: state_d = S_EMPTY;
      endcase
    end
    // Both handshake outputs follow the next state so they leave the flop stage directly.
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      ent0_q      <= ENTRY_RST;
      ent1_q      <= ENTRY_RST;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = ent0_q.pc;
  assign bus.out_opcode  = ent0_q.opcode;
  assign bus.out_rd      = ent0_q.rd;
  assign bus.out_rs1     = ent0_q.rs1;
  assign bus.out_rs2     = ent0_q.rs2;
  assign bus.out_funct3  = ent0_q.funct3;
  assign bus.out_funct7  = ent0_q.funct7;
  assign bus.out_shamt   = ent0_q.shamt;
  assign bus.out_imm     = ent0_q.imm;
  assign bus.out_fmt     = ent0_q.fmt;
  assign bus.out_illegal = ent0_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RV32I/RV64I decode stage sitting between the fetch stage and the register-read/execute stage. It extracts every instruction field and generates the sign-extended immediate for all base formats (R/I/S/B/U/J). It also flags illegal encodings. Results go into a two-entry elastic buffer with a valid/ready handshake on both sides and a pipeline flush input.

## Interface
- XLEN, 32: datapath width, 32 or 64; sets immediate/PC width and enables the RV64 opcodes.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered and incoming instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  PC of the decoded entry.
- out_opcode  out  7  instr[6:0].
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_shamt  out  6  instr[25:20]; bit 5 forced 0 when XLEN=32.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- out_illegal  out  1  encoding not legal for XLEN.

## Operation
- Decode is combinational on in_instr; decoded fields are captured only into the buffer.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I = [31:20]
  - S = {[31:25],[11:7]}
  - B = {[31],[7],[30:25],[11:8],0}
  - U = {[31:12],12'b0}
  - J = {[31],[19:12],[20],[30:21],0}
  - R/NONE give imm 0.
- Format map:
  - LUI 0110111 and AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, SYSTEM 1110011 → I.
  - BRANCH 1100011 → B.
  - STORE 0100011 → S.
  - OP 0110011 → R.
  - OP-IMM-32 0011011 → I, XLEN=64 only.
  - OP-32 0111011 → R, XLEN=64 only.
- out_illegal=1 and out_fmt=NONE for:
  - instr[1:0]≠11;
  - any unlisted opcode;
  - RV64-only opcodes when XLEN=32;
  - JALR with funct3≠000;
  - BRANCH with funct3 010/011;
  - OP-IMM shifts (funct3 001/101) with instr[25]=1 when XLEN=32.
  - Illegal entries still flow through the buffer in order.
- Buffer holds 0, 1 or 2 entries; states are EMPTY, ONE, TWO. The output always presents the oldest entry.
  - push = in_valid & in_ready & !flush; pop = out_valid & out_ready.
  - EMPTY: push → ONE.
  - ONE: push & !pop → TWO; pop & !push → EMPTY; push & pop → ONE, with the new entry replacing the old.
  - TWO: pop → ONE, second entry promoted; push impossible.
- in_ready is registered: it is 1 in EMPTY/ONE and 0 in TWO.
- flush has priority over push and pop: the next state is EMPTY and the instruction offered in the flush cycle is dropped.

## Timing
- Reset (async, immediate):
  - out_valid=0, in_ready=1, state EMPTY.
  - All payload outputs 0, except out_fmt=NONE(7).
- Latency: an instruction accepted at edge N appears on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 instruction/cycle while out_ready=1.
- out_* hold stable while out_valid=1 and out_ready=0.
- in_ready falls in the cycle after the buffer fills, so no combinational path exists from out_ready to in_ready.
- rst asserted mid-transfer discards all entries. Nothing is emitted until new pushes arrive after deassertion.
- flush and rst have no effect on in_instr sampling other than the drop described above.

## Test plan
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) → one cycle later: out_valid=1, opcode 0x13, rd=1, rs1=0, imm=0xFFFFFFFF, fmt=I, illegal=0.
- Push 0xFE000EE3 (beq x0,x0,-4) → fmt=B, imm=0xFFFFFFFC. Push 0x000010B7 (lui x1,1) → fmt=U, imm=0x00001000.
- Hold out_ready=0 and offer 3 instructions back-to-back:
  - the first two are accepted and in_ready=0 after the second;
  - raise out_ready → the three emerge in order, no drop or duplicate, then out_valid=0.
- With the buffer in TWO and in_valid=1, assert flush for one cycle → next cycle out_valid=0, in_ready=1, and the offered word never appears.
- Legality:
  - push 0x00000000 → illegal=1, fmt=NONE, imm=0;
  - push 0x02001093 (slli x1,x0,32): XLEN=32 → illegal=1; XLEN=64 → illegal=0, shamt=32.
- Assert rst asynchronously between edges while in ONE → out_valid=0 and out_fmt=7 immediately; in_ready=1 after release.
